// File: rtl/bitonic_network_32.sv
// Pipelined 32-record bitonic merge of two ascending 16-record tuples, with an aligned control sideband.
// Optional macro BITONIC_OUT_REG_EN adds one output register stage (latency 6 instead of 5).
module bitonic_network_32 #(
    parameter int DATA_WIDTH = 512,
    parameter int REC_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  switch_output,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] top_tuple,
    input  logic [DATA_WIDTH-1:0] i_elems_0,
    input  logic [DATA_WIDTH-1:0] i_elems_1,
    output logic [DATA_WIDTH-1:0] o_elems_0,
    output logic [DATA_WIDTH-1:0] o_elems_1,
    output logic                  o_switch_output,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_top_tuple
);
    localparam int N    = 32;
    localparam int HALF = 16;
    localparam int NSTG = 5;

    logic [REC_W-1:0]      net_in     [N];
    logic [REC_W-1:0]      stage_in   [NSTG][N];
    logic [REC_W-1:0]      stage_next [NSTG][N];
    logic [REC_W-1:0]      data_reg   [NSTG][N];
    logic [NSTG-1:0]       stall_reg;
    logic [NSTG-1:0]       switch_reg;
    logic [DATA_WIDTH-1:0] top_reg    [NSTG];

    logic [REC_W-1:0]      out_data   [N];
    logic                  out_stall;
    logic                  out_switch;
    logic [DATA_WIDTH-1:0] out_top;

    // Tuple A ascending followed by tuple B reversed forms one bitonic sequence.
    genvar gi, gs;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_build
            assign net_in[gi]        = i_elems_0[REC_W*gi +: REC_W];
            assign net_in[HALF + gi] = i_elems_1[REC_W*(HALF-1-gi) +: REC_W];
        end
    endgenerate

    generate
        for (gs = 0; gs < NSTG; gs++) begin : g_stage
            localparam int D = HALF >> gs;
            for (gi = 0; gi < N; gi++) begin : g_rec
                if (gs == 0) begin : g_first
                    assign stage_in[gs][gi] = net_in[gi];
                end else begin : g_chain
                    assign stage_in[gs][gi] = data_reg[gs-1][gi];
                end
                // Each comparator owns the pair (gi, gi+D); equal keys pass straight through.
                if ((gi & D) == 0) begin : g_cmp
                    logic swap;
                    assign swap = stage_in[gs][gi+D] < stage_in[gs][gi];
                    assign stage_next[gs][gi]   = swap ? stage_in[gs][gi+D] : stage_in[gs][gi];
                    assign stage_next[gs][gi+D] = swap ? stage_in[gs][gi]   : stage_in[gs][gi+D];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NSTG; s++) begin
                for (int k = 0; k < N; k++) begin
                    data_reg[s][k] <= '0;
                end
                top_reg[s] <= '0;
            end
            stall_reg  <= '1;
            switch_reg <= '0;
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                for (int k = 0; k < N; k++) begin
                    data_reg[s][k] <= stage_next[s][k];
                end
            end
            top_reg[0] <= top_tuple;
            for (int s = 1; s < NSTG; s++) begin
                top_reg[s] <= top_reg[s-1];
            end
            stall_reg  <= {stall_reg[NSTG-2:0], stall};
            switch_reg <= {switch_reg[NSTG-2:0], switch_output};
        end
    end

`ifdef BITONIC_OUT_REG_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N; k++) begin
                out_data[k] <= '0;
            end
            out_stall  <= 1'b1;
            out_switch <= 1'b0;
            out_top    <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                out_data[k] <= data_reg[NSTG-1][k];
            end
            out_stall  <= stall_reg[NSTG-1];
            out_switch <= switch_reg[NSTG-1];
            out_top    <= top_reg[NSTG-1];
        end
    end
`else
    generate
        for (gi = 0; gi < N; gi++) begin : g_out_direct
            assign out_data[gi] = data_reg[NSTG-1][gi];
        end
    endgenerate
    assign out_stall  = stall_reg[NSTG-1];
    assign out_switch = switch_reg[NSTG-1];
    assign out_top    = top_reg[NSTG-1];
`endif

    generate
        for (gi = 0; gi < HALF; gi++) begin : g_pack
            assign o_elems_0[REC_W*gi +: REC_W] = out_data[gi];
            assign o_elems_1[REC_W*gi +: REC_W] = out_data[HALF + gi];
        end
    endgenerate

    assign o_stall         = out_stall;
    assign o_switch_output = out_switch;
    assign o_top_tuple     = out_top;

endmodule

// File: tb/tb_bitonic_network_32.sv
// Self-checking bench for bitonic_network_32: directed cases plus random streaming against a sort-based model.
module tb_bitonic_network_32;
    localparam int RW = 32;
    localparam int DW = 512;
`ifdef BITONIC_OUT_REG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif
    localparam int NB2B = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sw_in, stall_in;
    logic [DW-1:0] top_in, a_in, b_in;
    logic [DW-1:0] lo_out, hi_out, top_out;
    logic          sw_out, stall_out;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bitonic_network_32 #(.DATA_WIDTH(DW), .REC_W(RW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .switch_output   (sw_in),
        .stall           (stall_in),
        .top_tuple       (top_in),
        .i_elems_0       (a_in),
        .i_elems_1       (b_in),
        .o_elems_0       (lo_out),
        .o_elems_1       (hi_out),
        .o_switch_output (sw_out),
        .o_stall         (stall_out),
        .o_top_tuple     (top_out)
    );

    function automatic logic [DW-1:0] pack_seq(input int start, input int step);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[k*RW +: RW] = 32'(start + step * k);
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_sorted(input bit narrow);
        logic [RW-1:0] t [16];
        logic [RW-1:0] key;
        logic [DW-1:0] v;
        int j;
        for (int k = 0; k < 16; k++) t[k] = narrow ? 32'($urandom_range(0, 40)) : $urandom();
        for (int i = 1; i < 16; i++) begin
            key = t[i];
            j = i - 1;
            while (j >= 0 && t[j] > key) begin
                t[j+1] = t[j];
                j--;
            end
            t[j+1] = key;
        end
        v = '0;
        for (int k = 0; k < 16; k++) v[k*RW +: RW] = t[k];
        return v;
    endfunction

    // Reference: merged result is simply the 32 keys of A and B sorted ascending, split in halves.
    task automatic ref_merge(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             output logic [DW-1:0] lo, output logic [DW-1:0] hi);
        logic [RW-1:0] t [32];
        logic [RW-1:0] key;
        int j;
        for (int k = 0; k < 16; k++) begin
            t[k]      = a[k*RW +: RW];
            t[16 + k] = b[k*RW +: RW];
        end
        for (int i = 1; i < 32; i++) begin
            key = t[i];
            j = i - 1;
            while (j >= 0 && t[j] > key) begin
                t[j+1] = t[j];
                j--;
            end
            t[j+1] = key;
        end
        lo = '0;
        hi = '0;
        for (int k = 0; k < 16; k++) begin
            lo[k*RW +: RW] = t[k];
            hi[k*RW +: RW] = t[16 + k];
        end
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic st,
                         input logic sw, input logic [DW-1:0] top);
        a_in = a; b_in = b; stall_in = st; sw_in = sw; top_in = top;
    endtask

    task automatic idle();
        drive('0, '0, 1'b1, 1'b0, '0);
    endtask

    // Presents one pair for a single cycle and returns once its result is on the outputs.
    task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        drive(a, b, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        idle();
        repeat (LAT - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] el, eh;
        rst_n = 1'b0;
        drive(pack_seq(0, 2), pack_seq(1, 2), 1'b0, 1'b1, pack_seq(9, 3));
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lo_out !== '0) begin fails++; $display("FAIL reset_lo got %h expected 0", lo_out); end
        checks++; if (hi_out !== '0) begin fails++; $display("FAIL reset_hi got %h expected 0", hi_out); end
        checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL reset_stall got %b expected 1", stall_out); end
        checks++; if (sw_out !== 1'b0) begin fails++; $display("FAIL reset_switch got %b expected 0", sw_out); end
        checks++; if (top_out !== '0) begin fails++; $display("FAIL reset_top got %h expected 0", top_out); end
        @(negedge clk);
        rst_n = 1'b1;
        ref_merge(pack_seq(0, 2), pack_seq(1, 2), el, eh);
        for (int c = 0; c < LAT; c++) begin
            @(posedge clk); #1;
            if (c == 0) idle();
            if (c < LAT - 1) begin
                checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL fill_stall c=%0d got %b expected 1", c, stall_out); end
                checks++; if (lo_out !== '0) begin fails++; $display("FAIL fill_lo c=%0d got %h expected 0", c, lo_out); end
                checks++; if (sw_out !== 1'b0) begin fails++; $display("FAIL fill_switch c=%0d got %b expected 0", c, sw_out); end
            end else begin
                checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL first_stall got %b expected 0", stall_out); end
                checks++; if (sw_out !== 1'b1) begin fails++; $display("FAIL first_switch got %b expected 1", sw_out); end
                checks++; if (top_out !== pack_seq(9, 3)) begin fails++; $display("FAIL first_top got %h expected %h", top_out, pack_seq(9, 3)); end
                checks++; if (lo_out !== el) begin fails++; $display("FAIL first_lo got %h expected %h", lo_out, el); end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_interleaved();
        run_pair(pack_seq(0, 2), pack_seq(1, 2));
        checks++; if (lo_out !== pack_seq(0, 1)) begin fails++; $display("FAIL interleaved_lo got %h expected %h", lo_out, pack_seq(0, 1)); end
        checks++; if (hi_out !== pack_seq(16, 1)) begin fails++; $display("FAIL interleaved_hi got %h expected %h", hi_out, pack_seq(16, 1)); end
        checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL interleaved_stall got %b expected 0", stall_out); end
        $display("test_interleaved done");
    endtask

    task automatic test_disjoint();
        logic [DW-1:0] a, b;
        a = pack_seq(100, 1);
        b = pack_seq(1, 1);
        run_pair(a, b);
        checks++; if (lo_out !== b) begin fails++; $display("FAIL disjoint_ab_lo got %h expected %h", lo_out, b); end
        checks++; if (hi_out !== a) begin fails++; $display("FAIL disjoint_ab_hi got %h expected %h", hi_out, a); end
        run_pair(b, a);
        checks++; if (lo_out !== b) begin fails++; $display("FAIL disjoint_ba_lo got %h expected %h", lo_out, b); end
        checks++; if (hi_out !== a) begin fails++; $display("FAIL disjoint_ba_hi got %h expected %h", hi_out, a); end
        $display("test_disjoint done");
    endtask

    task automatic test_duplicates();
        logic [DW-1:0] b, el, eh;
        b = pack_seq(7, 0);
        b[0 +: RW] = '0;
        b[15*RW +: RW] = 32'hFFFF_FFFF;
        el = pack_seq(7, 0);
        el[0 +: RW] = '0;
        eh = pack_seq(7, 0);
        eh[15*RW +: RW] = 32'hFFFF_FFFF;
        run_pair(pack_seq(7, 0), b);
        checks++; if (lo_out !== el) begin fails++; $display("FAIL dup_lo got %h expected %h", lo_out, el); end
        checks++; if (hi_out !== eh) begin fails++; $display("FAIL dup_hi got %h expected %h", hi_out, eh); end
        $display("test_duplicates done");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] aq [NB2B];
        logic [DW-1:0] bq [NB2B];
        logic [DW-1:0] tq [NB2B];
        logic [DW-1:0] elq [NB2B];
        logic [DW-1:0] ehq [NB2B];
        logic          sq [NB2B];
        logic          wq [NB2B];
        int idx;
        for (int i = 0; i < NB2B; i++) begin
            aq[i] = rand_sorted(i[0]);
            bq[i] = rand_sorted(i[1]);
            tq[i] = {16{$urandom()}};
            sq[i] = 1'($urandom_range(0, 1));
            wq[i] = 1'($urandom_range(0, 1));
            ref_merge(aq[i], bq[i], elq[i], ehq[i]);
        end
        for (int c = 0; c < NB2B + LAT - 1; c++) begin
            @(negedge clk);
            if (c < NB2B) drive(aq[c], bq[c], sq[c], wq[c], tq[c]);
            else idle();
            @(posedge clk); #1;
            idx = c - (LAT - 1);
            if (idx >= 0) begin
                checks++; if (lo_out !== elq[idx]) begin fails++; $display("FAIL b2b_lo #%0d got %h expected %h", idx, lo_out, elq[idx]); end
                checks++; if (hi_out !== ehq[idx]) begin fails++; $display("FAIL b2b_hi #%0d got %h expected %h", idx, hi_out, ehq[idx]); end
                checks++; if (stall_out !== sq[idx]) begin fails++; $display("FAIL b2b_stall #%0d got %b expected %b", idx, stall_out, sq[idx]); end
                checks++; if (sw_out !== wq[idx]) begin fails++; $display("FAIL b2b_switch #%0d got %b expected %b", idx, sw_out, wq[idx]); end
                checks++; if (top_out !== tq[idx]) begin fails++; $display("FAIL b2b_top #%0d got %h expected %h", idx, top_out, tq[idx]); end
                $display("b2b #%0d stall=%b switch=%b", idx, stall_out, sw_out);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [DW-1:0] a, b, el, eh;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            drive(rand_sorted(1'b0), rand_sorted(1'b0), 1'b0, 1'b1, {16{$urandom() | 32'h1}});
            @(posedge clk);
        end
        #1;
        checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL pre_reset_stall got %b expected 0", stall_out); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (lo_out !== '0) begin fails++; $display("FAIL midrst_lo got %h expected 0", lo_out); end
        checks++; if (hi_out !== '0) begin fails++; $display("FAIL midrst_hi got %h expected 0", hi_out); end
        checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL midrst_stall got %b expected 1", stall_out); end
        checks++; if (sw_out !== 1'b0) begin fails++; $display("FAIL midrst_switch got %b expected 0", sw_out); end
        checks++; if (top_out !== '0) begin fails++; $display("FAIL midrst_top got %h expected 0", top_out); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL held_rst_stall got %b expected 1", stall_out); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL post_rst_stall c=%0d got %b expected 1", c, stall_out); end
            checks++; if (hi_out !== '0) begin fails++; $display("FAIL post_rst_hi c=%0d got %h expected 0", c, hi_out); end
        end
        a = rand_sorted(1'b0);
        b = rand_sorted(1'b1);
        ref_merge(a, b, el, eh);
        @(negedge clk);
        drive(a, b, 1'b0, 1'b0, '0);
        for (int c = 0; c < LAT; c++) begin
            @(posedge clk); #1;
            if (c == 0) idle();
            if (c < LAT - 1) begin
                checks++; if (stall_out !== 1'b1) begin fails++; $display("FAIL relat_stall c=%0d got %b expected 1", c, stall_out); end
            end else begin
                checks++; if (stall_out !== 1'b0) begin fails++; $display("FAIL relat_valid got %b expected 0 at LAT=%0d", stall_out, LAT); end
                checks++; if (lo_out !== el) begin fails++; $display("FAIL relat_lo got %h expected %h", lo_out, el); end
                checks++; if (hi_out !== eh) begin fails++; $display("FAIL relat_hi got %h expected %h", hi_out, eh); end
            end
        end
        $display("test_reset_mid_stream done (LAT=%0d)", LAT);
    endtask

    initial begin
        test_reset();
        test_interleaved();
        test_disjoint();
        test_duplicates();
        test_back_to_back();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
